// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the unified-memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STREAK_W = 4;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection; D wins ties unless fetch is starved
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  input  logic starved,
  output logic i_gnt,
  output logic d_gnt,
  output logic sel
);
  always_comb begin
    sel = (d_req && !(i_req && starved)) ? PORT_D : PORT_I;
    i_gnt = en && i_req && sel == PORT_I;
    d_gnt = en && d_req && sel == PORT_D;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between fetch and data ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  state_t state, state_n;
  port_t sel_q;
  logic sel, we_q, last;
  logic [2:0] cnt;
  logic [STREAK_W-1:0] streak;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  localparam logic [STREAK_W-1:0] LIM = STREAK_W'(STARVE_LIMIT);

  mem_arb_pick u_pick (
    .en(state == IDLE && reset_n),
    .i_req(i_req),
    .d_req(d_req),
    .starved(streak == LIM),
    .i_gnt(i_gnt),
    .d_gnt(d_gnt),
    .sel(sel)
  );

  always_comb begin
    last = state == ACCESS && cnt == 3'd0;
    state_n = state == IDLE ? ((i_gnt || d_gnt) ? ACCESS : IDLE) : (last ? IDLE : ACCESS);
    mem_a = state == ACCESS ? addr_q : '0;
    mem_wd = state == ACCESS ? wd_q : '0;
    mem_we = last && we_q && reset_n;
  end

  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_n;

  // Request latches need no reset: they are only observed while in ACCESS.
  always_ff @(posedge clk)
    if (i_gnt || d_gnt) begin
      sel_q <= port_t'(sel);
      we_q <= d_gnt && d_we;
      addr_q <= d_gnt ? d_addr : i_addr;
      wd_q <= d_wdata;
      cnt <= 3'(WAIT_STATES);
    end else if (state == ACCESS && cnt != 3'd0) cnt <= cnt - 3'd1;

  always_ff @(posedge clk)
    if (!reset_n) begin
      streak <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      i_rvalid <= last && sel_q == PORT_I;
      d_rvalid <= last && sel_q == PORT_D;
      if (last && sel_q == PORT_I) i_rdata <= mem_rd;
      if (last && sel_q == PORT_D && !we_q) d_rdata <= mem_rd;
      if (i_gnt || (d_gnt && !i_req)) streak <= '0;
      else if (d_gnt && streak != LIM) streak <= streak + 1'b1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the arbiter with zero and three wait states
module tb_mem_arbiter;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;

  logic i_req, d_req, d_we, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_we;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_a, mem_wd, mem_rd;
  logic i3_req, d3_req, d3_we, i3_gnt, d3_gnt, i3_rvalid, d3_rvalid, mem3_we;
  logic [31:0] i3_addr, d3_addr, d3_wdata, i3_rdata, d3_rdata, mem3_a, mem3_wd, mem3_rd;
  logic [31:0] ram0 [0:63];
  logic [31:0] ram3 [0:63];
  logic [9:0] exp_i = 10'b10_0001_0000;
  int n_cmp = 0, n_err = 0;

  assign mem_rd = ram0[mem_a[7:2]];
  assign mem3_rd = ram3[mem3_a[7:2]];
  always @(posedge clk) if (mem_we) ram0[mem_a[7:2]] = mem_wd;
  always @(posedge clk) if (mem3_we) ram3[mem3_a[7:2]] = mem3_wd;

  mem_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(4)) u0 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  mem_arbiter #(.WAIT_STATES(3), .STARVE_LIMIT(4)) u3 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i3_req), .i_addr(i3_addr), .i_gnt(i3_gnt), .i_rvalid(i3_rvalid), .i_rdata(i3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
    .mem_a(mem3_a), .mem_we(mem3_we), .mem_wd(mem3_wd), .mem_rd(mem3_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    {i_req, d_req, d_we, i3_req, d3_req, d3_we} = '0;
    {i_addr, d_addr, d_wdata, i3_addr, d3_addr, d3_wdata} = '0;
    for (int i = 0; i < 64; i++) begin
      ram0[i] = '0;
      ram3[i] = '0;
    end
    ram0[4] = 32'h20080005;
    ram0[5] = 32'hAAAA0005;
    ram0[17] = 32'hBBBB0011;
    ram0[32] = 32'h11111111;
    ram3[2] = 32'hCAFEF00D;
    // requests held during reset must not be granted
    i_req = 1; i_addr = 32'h10; d3_req = 1;
    tick; tick; #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d3_gnt", d3_gnt, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_a", mem_a, 0);
    d3_req = 0;
    reset_n = 1; #1;
    chk("f_i_gnt", i_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    tick; i_req = 0; #1;
    chk("f_mem_a", mem_a, 32'h10);
    chk("f_rvalid_early", i_rvalid, 0);
    chk("f_mem_we", mem_we, 0);
    tick; #1;
    chk("f_i_rvalid", i_rvalid, 1);
    chk("f_i_rdata", i_rdata, 32'h20080005);
    chk("f_d_rvalid", d_rvalid, 0);
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; #1;
    chk("st_d_gnt", d_gnt, 1);
    tick; d_req = 0; #1;
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_a", mem_a, 32'h40);
    chk("st_mem_wd", mem_wd, 32'hDEADBEEF);
    tick; #1;
    chk("st_we_once", mem_we, 0);
    chk("st_d_rvalid", d_rvalid, 1);
    chk("st_d_rdata", d_rdata, 0);
    chk("st_ram", ram0[16], 32'hDEADBEEF);
    d_req = 1; d_we = 0; #1;
    chk("ld_d_gnt", d_gnt, 1);
    tick; d_req = 0; #1;
    tick; #1;
    chk("ld_d_rvalid", d_rvalid, 1);
    chk("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("ld_i_rdata", i_rdata, 32'h20080005);
    // both ports requesting continuously: fetch forced every fifth grant
    i_req = 1; d_req = 1; i_addr = 32'h10; d_addr = 32'h40;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("starve_i_gnt", i_gnt, exp_i[k]);
      chk("starve_d_gnt", d_gnt, !exp_i[k]);
      tick; tick;
    end
    i_req = 0; d_req = 0; #1;
    chk("starve_i_rvalid", i_rvalid, 1);
    chk("starve_d_rvalid", d_rvalid, 0);
    d3_req = 1; d3_we = 0; d3_addr = 32'h8; #1;
    chk("ws3_gnt", d3_gnt, 1);
    for (int c = 1; c <= 4; c++) begin
      tick; #1;
      chk("ws3_mem_a", mem3_a, 32'h8);
      chk("ws3_rvalid_early", d3_rvalid, 0);
      chk("ws3_no_gnt", d3_gnt, 0);
    end
    tick; #1;
    chk("ws3_rvalid", d3_rvalid, 1);
    chk("ws3_rdata", d3_rdata, 32'hCAFEF00D);
    chk("ws3_regnt", d3_gnt, 1);
    d3_req = 0;
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h55555555; #1;
    chk("rs_d_gnt", d_gnt, 1);
    tick; d_req = 0; reset_n = 0; #1;
    chk("rs_mem_we", mem_we, 0);
    tick; reset_n = 1; #1;
    chk("rs_ram", ram0[32], 32'h11111111);
    chk("rs_d_rvalid", d_rvalid, 0);
    chk("rs_i_rvalid", i_rvalid, 0);
    chk("rs_i_rdata", i_rdata, 0);
    chk("rs_d_rdata", d_rdata, 0);
    chk("rs_mem_a", mem_a, 0);
    tick; #1;
    chk("rs_no_rvalid", d_rvalid, 0);
    i_req = 1; i_addr = 32'h14; #1;
    chk("alt1_gnt", i_gnt, 1);
    tick; i_req = 0; tick; #1;
    chk("alt1_i_rvalid", i_rvalid, 1);
    chk("alt1_i_rdata", i_rdata, 32'hAAAA0005);
    chk("alt1_d_rvalid", d_rvalid, 0);
    chk("alt1_d_rdata", d_rdata, 0);
    d_req = 1; d_we = 0; d_addr = 32'h47; #1;
    chk("alt2_gnt", d_gnt, 1);
    tick; d_req = 0; #1;
    chk("alt2_mem_a", mem_a, 32'h47);
    tick; #1;
    chk("alt2_d_rvalid", d_rvalid, 1);
    chk("alt2_d_rdata", d_rdata, 32'hBBBB0011);
    chk("alt2_i_rvalid", i_rvalid, 0);
    chk("alt2_i_rdata", i_rdata, 32'hAAAA0005);
    i_req = 1; i_addr = 32'h10; #1;
    chk("alt3_gnt", i_gnt, 1);
    tick; i_req = 0; tick; #1;
    chk("alt3_i_rvalid", i_rvalid, 1);
    chk("alt3_i_rdata", i_rdata, 32'h20080005);
    chk("alt3_d_rdata", d_rdata, 32'hBBBB0011);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, word-aligned memory (byte address in, asynchronous read, write on clock edge) between the CPU's instruction-fetch port and data port, so fetch and load/store can live in one unified RAM. A small FSM accepts one request at a time, holds the memory bus for a configurable number of wait states, and returns the read data registered. A starvation counter bounds how long data traffic can lock out fetch.

## Interface
- WAIT_STATES, 0: extra cycles the memory bus is held per access (0..7).
- STARVE_LIMIT, 4: consecutive contested D grants before I is forced (1..15).
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held with d_we, d_addr, d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid or store done
- d_rdata  out  32  loaded word
- mem_a  out  32  memory byte address (memory uses a[31:2])
- mem_we  out  1  memory write enable
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, combinational from mem_a

## Operation
- FSM states: IDLE, ACCESS. A response is signalled by a registered rvalid pulse on the cycle that returns to IDLE.
- IDLE: if any request is present, pick a winner, assert its gnt (combinational from req and state), latch port, addr, we, wdata, and go to ACCESS with wait counter = WAIT_STATES.
- Pick rule: only one request present -> it wins. Both present -> D wins unless streak == STARVE_LIMIT, in which case I wins.
- Streak counter (4 bit): +1 on a D grant with i_req high. Cleared on any I grant or on a D grant with i_req low. Saturates at STARVE_LIMIT.
- ACCESS: drive mem_a/mem_wd from latches. Count down. On the final cycle (counter == 0):
  - a load captures mem_rd into that port's rdata register;
  - a store asserts mem_we for exactly this cycle;
  - next state IDLE, and the winner's rvalid is set for the next cycle.
- Store completion pulses d_rvalid; d_rdata stays unchanged. I port never writes.
- Address bits [1:0] pass through unchanged and are ignored by the memory.
- Outside ACCESS: mem_a = 0, mem_wd = 0, mem_we = 0.
- mem_we is also gated combinationally by reset_n, so no write commits at an edge where reset_n is low.
- Reset (synchronous, any state): state IDLE, streak 0, i/d_rdata 0, i/d_rvalid 0. The in-flight access is dropped and no rvalid follows. Gnt outputs are 0 while reset_n is low.

## Timing
- Grant cycle N (IDLE) -> ACCESS cycles N+1 .. N+1+WAIT_STATES -> rvalid in cycle N+WAIT_STATES+2, coinciding with IDLE.
- A new grant may occur in the same cycle as the previous rvalid, so the sustained rate is one access per WAIT_STATES+2 cycles.
- gnt is asserted only in IDLE and never to both ports in one cycle. At most one access is outstanding.
- rdata holds its value until the next load to the same port.
- Requests dropped before gnt are legal and simply not served.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS);
  - the port-select encoding (PORT_I, PORT_D);
  - width constants (ADDR_W = 32, DATA_W = 32, STREAK_W = 4).
- Sub-module mem_arb_pick is natural: combinational winner selection from i_req, d_req and the streak/limit compare. Its outputs are the grants and the winner select.
- The top level contains the FSM, wait counter, streak counter, latches and response registers.

## Test plan
- WAIT_STATES=0, I-only fetch of 0x00000010 with RAM word 4 = 0x20080005:
  - i_gnt in cycle N;
  - mem_a = 0x10 in N+1;
  - i_rvalid with i_rdata = 0x20080005 in N+2.
- D store 0xDEADBEEF to 0x00000040, then load from 0x00000040:
  - mem_we high for exactly one cycle;
  - d_rvalid on the store with d_rdata unchanged;
  - the load returns 0xDEADBEEF.
- Both requests held permanently, STARVE_LIMIT=4: grant sequence D,D,D,D,I,D,D,D,D,I; the streak clears after each I.
- WAIT_STATES=3: grant at N, rvalid at N+5; mem_a stable for 4 cycles; next grant possible at N+5.
- Store in flight with reset_n pulled low on its final ACCESS cycle:
  - mem_we stays 0 and the RAM is unchanged;
  - next cycle the FSM is IDLE and all rvalid/rdata are 0;
  - no rvalid for the dropped access.
- Back-to-back loads alternating ports with only one requester present at a time: each rvalid goes to the correct port; the other port's rdata is unchanged.
